mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences one single-ported unified memory between the instruction-fetch stage and the data-memory stage of the pipelined CPU. Data requests come straight from the decoded MemRead/MemWrite control lines. Instruction fetches come from the PC stage. The arbiter grants one requester at a time and holds the memory handshake until the memory reports ready. It returns data with a one-cycle ack pulse and drives a pipeline stall while any request is outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; valid only while if_ack=1
- if_ack  out  1  one-cycle completion pulse
- dm_read  in  1  data load request (MemRead)
- dm_write  in  1  data store request (MemWrite)
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid only while dm_ack=1
- dm_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  write enable; qualified by mem_req
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; sampled when mem_ready=1
- mem_ready  in  1  memory completion; meaningful only while mem_req=1
- stall  out  1  freeze PC/IF/ID registers
- err  out  1  sticky: dm_read and dm_write were seen high together

## Operation
- FSM states: IDLE, DATA, FETCH.
- Arbitration in IDLE:
  - dm_pend = dm_read|dm_write; if_pend = if_req.
  - A requester whose ack is high in the current cycle is masked.
  - Single pending requester: it wins.
  - Both pending: round-robin on last_grant. Reset value of last_grant = FETCH, so data wins the first conflict.
- Grant into DATA or FETCH: register mem_addr, mem_we (=dm_write for data, 0 for fetch) and mem_wdata, then raise mem_req. All four are held stable until mem_ready.
- DATA/FETCH with mem_ready=1:
  - Capture mem_rdata into the matching *_rdata register.
  - Pulse the matching ack next cycle.
  - Update last_grant and return to IDLE.
- dm_read&dm_write together: treat as a write and set err. err clears only on rst.
- A requester that drops its request before ack is a protocol violation. The transaction still completes and the ack still pulses.
- stall = (if_req & ~if_ack) | (dm_pend & ~dm_ack). This is combinational from the inputs and the registered acks.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, err=0, last_grant=FETCH.
- rst mid-transaction: abandon the transaction and drop mem_req the next cycle. No ack is issued. The memory tolerates abandonment.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: mem_req=1.
- mem_ready in cycle k≥1 gives ack=1 in cycle k+1; the FSM is in IDLE in cycle k+1.
- Minimum request-to-ack latency is 2 cycles.
- A new grant is decided in cycle k+1, so the next mem_req is at k+2. There is one dead memory cycle between transactions.
- mem_req=0 for exactly one cycle between back-to-back transactions.
- Acks are never simultaneous. At most one ack is high per cycle.
- No wait-state limit. mem_req holds indefinitely until mem_ready.

## Structure
- Shared package cpu_pkg holds:
  - the state enum (IDLE/DATA/FETCH)
  - the grant encoding (GNT_DATA, GNT_FETCH)
  - the ADDR_W/DATA_W defaults
- One natural sub-module: rr_arb2, a two-requester round-robin picker. Inputs are two request bits and last_grant; output is the one-hot grant.

## Test plan
- Fetch only, 0x0000_0040, memory returns 0x2008_0005 with mem_ready on cycle 1:
  - if_ack=1 on cycle 2, with if_rdata=0x2008_0005.
  - stall high on cycles 0–1, low on cycle 2.
- Store to 0x100 with wdata 0xDEAD_BEEF and 3 wait states:
  - mem_we=1 with mem_addr/mem_wdata stable for 4 cycles.
  - dm_ack one cycle after mem_ready.
  - No if_ack during this window.
- if_req and dm_read raised together after reset, both held:
  - Data is served first.
  - Fetch is served next, with mem_req low for exactly one cycle between.
  - Repeat the conflict: grants alternate.
- dm_read=dm_write=1: a write is performed and err=1, and err stays 1 until rst.
- rst asserted 2 cycles into a 5-wait-state fetch:
  - mem_req=0 and state=IDLE the next cycle.
  - No if_ack, and all outputs at their reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory-port arbiter.
//   state_t    : arbiter FSM states (IDLE, DATA, FETCH)
//   grant_t    : which requester was granted most recently
//   GNT_BIT_*  : bit positions in the one-hot grant vector
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    typedef enum logic {
        GNT_DATA  = 1'b0,
        GNT_FETCH = 1'b1
    } grant_t;

    localparam int unsigned GNT_BIT_DATA  = 0;
    localparam int unsigned GNT_BIT_FETCH = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker.
//   req_data   in  : data-stage request (already masked by the caller)
//   req_fetch  in  : fetch request (already masked by the caller)
//   last_grant in  : requester served most recently (GNT_DATA/GNT_FETCH)
//   gnt        out : one-hot grant, bit GNT_BIT_DATA / GNT_BIT_FETCH
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       req_data,
    input  logic       req_fetch,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        // On a conflict, the requester not served last time wins.
        if (req_data && (!req_fetch || last_grant == GNT_FETCH)) begin
            gnt[GNT_BIT_DATA] = 1'b1;
        end else if (req_fetch) begin
            gnt[GNT_BIT_FETCH] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and
// the data-memory stage. One transaction at a time; the memory handshake is
// held until mem_ready, and completion is signalled by a one-cycle ack.
//   clk, rst           : clock, synchronous active-high reset
//   if_req/if_addr     : fetch request / address; if_rdata+if_ack return
//   dm_read/dm_write   : data load/store request; dm_addr, dm_wdata
//   dm_rdata/dm_ack    : load data and completion pulse
//   mem_*              : memory handshake (req, we, addr, wdata, rdata, ready)
//   stall              : freeze PC/IF/ID while any request is outstanding
//   err                : sticky, set when dm_read and dm_write are both high
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              err
);

    state_t     state;
    grant_t     last_grant;
    logic       dm_pend;
    logic       if_pend;
    logic       dm_cand;
    logic       if_cand;
    logic [1:0] gnt;

    assign dm_pend = dm_read | dm_write;
    assign if_pend = if_req;

    // A requester is still holding its line during its ack cycle; mask it so
    // the same request is not served twice.
    assign dm_cand = dm_pend & ~dm_ack;
    assign if_cand = if_pend & ~if_ack;

    assign stall = (if_req & ~if_ack) | (dm_pend & ~dm_ack);

    rr_arb2 u_rr_arb2 (
        .req_data   (dm_cand),
        .req_fetch  (if_cand),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_FETCH;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            err        <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;

            if (dm_read && dm_write) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (gnt[GNT_BIT_DATA]) begin
                        state     <= DATA;
                        mem_req   <= 1'b1;
                        // read+write together is performed as a store
                        mem_we    <= dm_write;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (gnt[GNT_BIT_FETCH]) begin
                        state     <= FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end

                DATA: begin
                    if (mem_ready) begin
                        dm_rdata   <= mem_rdata;
                        dm_ack     <= 1'b1;
                        last_grant <= GNT_DATA;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        state      <= IDLE;
                    end
                end

                FETCH: begin
                    if (mem_ready) begin
                        if_rdata   <= mem_rdata;
                        if_ack     <= 1'b1;
                        last_grant <= GNT_FETCH;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
